// File: rtl/char_pkg.sv
// char_pkg: shared types and constants for the character health controller
package char_pkg;
  localparam int HP_W = 4;
  localparam logic [1:0] GAME_PLAY = 2'b01;
  typedef enum logic [1:0] {IDLE, LIVE, INVULN, DEAD} hp_state_e;
endpackage

// File: rtl/char_hp_ctrl_if.sv
// char_hp_ctrl_if: damage/heal request bus between requesters (master) and health controller (slave)
//   dmg_req/dmg_amt (NSRC sources, 4-bit amount slices), dmg_ack; heal_req/heal_amt, heal_ack
interface char_hp_ctrl_if #(parameter int NSRC = 4);
  logic [NSRC-1:0]   dmg_req;
  logic [4*NSRC-1:0] dmg_amt;
  logic [NSRC-1:0]   dmg_ack;
  logic              heal_req;
  logic [3:0]        heal_amt;
  logic              heal_ack;
  modport master (output dmg_req, dmg_amt, heal_req, heal_amt, input dmg_ack, heal_ack);
  modport slave  (input dmg_req, dmg_amt, heal_req, heal_amt, output dmg_ack, heal_ack);
endinterface

// File: rtl/char_hp_ctrl_rr_arbiter.sv
// rr_arbiter: round-robin pick of one requester, searching upward from ptr
//   req -> gnt (one-hot), idx (granted index), any (some request present)
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        idx = IW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
    gnt = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/char_hp_ctrl.sv
// char_hp_ctrl: player HP register with round-robin damage arbitration, heal, i-frames and alive flag
//   clk, rst (async, active low), frame_tick, game_active, game_start, max_hp; bus (slave modport);
//   char_hp, alive, invuln, hit_pulse. Optional HP regen when CHAR_HP_REGEN_EN is defined.
module char_hp_ctrl
  import char_pkg::*;
#(
  parameter int NSRC     = 4,
  parameter int IFRAMES  = 30,
  parameter int REGEN_FR = 120
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            frame_tick,
  input  logic [1:0]      game_active,
  input  logic            game_start,
  input  logic [HP_W-1:0] max_hp,
  char_hp_ctrl_if.slave   bus,
  output logic [HP_W-1:0] char_hp,
  output logic            alive,
  output logic            invuln,
  output logic            hit_pulse
);
  localparam int IW = $clog2(NSRC);
  if (NSRC < 2 || IFRAMES < 1 || IFRAMES > 255 || REGEN_FR < 1) begin : g_bad
    $error("char_hp_ctrl: parameter out of range");
  end
  hp_state_e state, state_n;
  logic [HP_W-1:0] hp_c, hp_n, max_q, max_n, amt, start_hp;
  logic [IW-1:0] ptr, ptr_n, gidx;
  logic [7:0] ifr, ifr_n;
  logic [NSRC-1:0] req_m, gnt, dack_n;
  logic gany, run, heal_ok, hack_n, hit_n;
  logic [HP_W:0] heal_sum;
  // a request whose ack is showing this cycle is the one just served, not a new hit
  assign req_m = bus.dmg_req & ~bus.dmg_ack;
  assign heal_ok = bus.heal_req & ~bus.heal_ack;
  assign run = game_active == GAME_PLAY;
  assign amt = bus.dmg_amt[HP_W*gidx +: HP_W];
  assign start_hp = max_hp == '0 ? HP_W'(1) : max_hp;
  assign heal_sum = {1'b0, char_hp} + {1'b0, bus.heal_amt};
  assign alive = state == LIVE || state == INVULN;
  assign invuln = state == INVULN;
  rr_arbiter #(.N(NSRC)) u_arb (.req(req_m), .ptr(ptr), .gnt(gnt), .idx(gidx), .any(gany));
  always_comb begin
    state_n = state;
    hp_c = char_hp;
    max_n = max_q;
    ptr_n = ptr;
    ifr_n = ifr;
    dack_n = '0;
    hack_n = 1'b0;
    hit_n = 1'b0;
    if (game_start) begin
      state_n = LIVE;
      hp_c = start_hp;
      max_n = start_hp;
      ifr_n = '0;
    end else if (state != IDLE && !run) begin
      state_n = IDLE;
    end else if (state == LIVE && gany) begin
      dack_n = gnt;
      hit_n = amt != '0;
      hp_c = amt >= char_hp ? '0 : char_hp - amt;
      ptr_n = gidx == IW'(NSRC - 1) ? '0 : gidx + 1'b1;
      state_n = amt >= char_hp ? DEAD : amt != '0 ? INVULN : LIVE;
      ifr_n = amt != '0 ? 8'(IFRAMES) : ifr;
    end else begin
      dack_n = (state == INVULN || state == DEAD) ? req_m : '0;
      hack_n = heal_ok && alive;
      hp_c = hack_n ? (heal_sum > {1'b0, max_q} ? max_q : heal_sum[HP_W-1:0]) : char_hp;
      if (state == INVULN && frame_tick) begin
        ifr_n = ifr - 1'b1;
        state_n = ifr <= 8'd1 ? LIVE : INVULN;
      end
    end
  end
`ifdef CHAR_HP_REGEN_EN
  localparam int RW = $clog2(REGEN_FR + 1);
  logic [RW-1:0] rg;
  logic rg_clr, rg_hit;
  assign rg_clr = game_start || !run || state != LIVE || gany || heal_ok;
  assign rg_hit = !rg_clr && frame_tick && rg == RW'(REGEN_FR - 1);
  assign hp_n = rg_hit && hp_c < max_q ? hp_c + 1'b1 : hp_c;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rg <= '0;
    else rg <= (rg_clr || rg_hit) ? '0 : rg + RW'(frame_tick);
  end
`else
  assign hp_n = hp_c;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      char_hp <= '0;
      max_q <= '0;
      ptr <= '0;
      ifr <= '0;
      bus.dmg_ack <= '0;
      bus.heal_ack <= 1'b0;
      hit_pulse <= 1'b0;
    end else begin
      state <= state_n;
      char_hp <= hp_n;
      max_q <= max_n;
      ptr <= ptr_n;
      ifr <= ifr_n;
      bus.dmg_ack <= dack_n;
      bus.heal_ack <= hack_n;
      hit_pulse <= hit_n;
    end
  end
endmodule

// File: tb/tb_char_hp_ctrl.sv
// tb_char_hp_ctrl: directed stimulus, per-cycle compare against a behavioural health model
module tb_char_hp_ctrl;
  localparam int NS = 4;
  localparam int IFR = 30;
  localparam int RGF = 120;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic [1:0] game_active = 2'b01;
  logic game_start = 1'b0;
  logic [3:0] max_hp = '0;
  logic [3:0] char_hp;
  logic alive, invuln, hit_pulse;
  bit chk_en = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  char_hp_ctrl_if #(.NSRC(NS)) bus ();
  char_hp_ctrl #(.NSRC(NS), .IFRAMES(IFR), .REGEN_FR(RGF)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .game_active(game_active),
    .game_start(game_start), .max_hp(max_hp), .bus(bus), .char_hp(char_hp),
    .alive(alive), .invuln(invuln), .hit_pulse(hit_pulse)
  );
  always #5 clk = ~clk;
  // model: mode 0 idle, 1 live, 2 invulnerable, 3 dead
  int m_mode = 0, e_hp = 0, m_max = 0, m_ptr = 0, m_ifr = 0, m_rg = 0;
  logic [NS-1:0] e_dack = '0;
  bit e_hack = 1'b0, e_hit = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; e_hp = 0; m_max = 0; m_ptr = 0; m_ifr = 0; m_rg = 0;
      e_dack = '0; e_hack = 1'b0; e_hit = 1'b0;
    end else begin : step
      automatic logic [NS-1:0] pend = bus.dmg_req & ~e_dack;
      automatic bit hpend = bus.heal_req && !e_hack;
      automatic int g = -1;
      automatic int a;
      for (int k = 0; k < NS; k++)
        if (g < 0 && pend[(m_ptr + k) % NS]) g = (m_ptr + k) % NS;
      e_dack = '0; e_hack = 1'b0; e_hit = 1'b0;
      if (game_start) begin
        m_max = (max_hp == 0) ? 1 : int'(max_hp);
        e_hp = m_max; m_mode = 1; m_ifr = 0; m_rg = 0;
      end else if (m_mode != 0 && game_active != 2'b01) begin
        m_mode = 0; m_rg = 0;
      end else if (m_mode == 1 && g >= 0) begin
        a = int'(bus.dmg_amt[4*g +: 4]);
        e_dack[g] = 1'b1;
        e_hit = a > 0;
        e_hp = (e_hp - a < 0) ? 0 : e_hp - a;
        m_ptr = (g + 1) % NS;
        m_rg = 0;
        if (e_hp == 0) m_mode = 3;
        else if (a > 0) begin m_mode = 2; m_ifr = IFR; end
      end else begin
        if (m_mode == 2 || m_mode == 3) e_dack = pend;
        if ((m_mode == 1 || m_mode == 2) && hpend) begin
          e_hack = 1'b1;
          e_hp = (e_hp + int'(bus.heal_amt) > m_max) ? m_max : e_hp + int'(bus.heal_amt);
        end
`ifdef CHAR_HP_REGEN_EN
        if (m_mode != 1 || hpend) m_rg = 0;
        else if (frame_tick) begin
          m_rg++;
          if (m_rg == RGF) begin m_rg = 0; if (e_hp < m_max) e_hp++; end
        end
`endif
        if (m_mode == 2 && frame_tick) begin
          m_ifr--;
          if (m_ifr == 0) m_mode = 1;
        end
      end
    end
  end
  task automatic lit(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    if (chk_en) begin
      lit("hp", int'(char_hp), e_hp);
      lit("alive", int'(alive), int'(m_mode == 1 || m_mode == 2));
      lit("invuln", int'(invuln), int'(m_mode == 2));
      lit("hit_pulse", int'(hit_pulse), int'(e_hit));
      lit("dmg_ack", int'(bus.dmg_ack), int'(e_dack));
      lit("heal_ack", int'(bus.heal_ack), int'(e_hack));
    end
  end
  task automatic cyc(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic ticks(int n);
    repeat (n) begin frame_tick = 1'b1; cyc(1); frame_tick = 1'b0; cyc(1); end
  endtask
  task automatic hit(int src, int a);
    bus.dmg_req[src] = 1'b1;
    bus.dmg_amt[4*src +: 4] = 4'(a);
    cyc(1);
    bus.dmg_req = '0;
  endtask
  task automatic start(int m);
    max_hp = 4'(m);
    game_start = 1'b1;
    cyc(1);
    game_start = 1'b0;
  endtask
  initial begin
    bus.dmg_req = '0; bus.dmg_amt = '0; bus.heal_req = 1'b0; bus.heal_amt = '0;
    cyc(1);
    chk_en = 1'b1;
    cyc(1);
    lit("rst_hp", int'(char_hp), 0);
    lit("rst_alive", int'(alive), 0);
    rst = 1'b1;
    cyc(1);
    start(8);
    lit("start_hp", int'(char_hp), 8);
    lit("start_alive", int'(alive), 1);
    lit("model_start_hp", e_hp, 8);
    bus.dmg_amt = {4'd0, 4'd0, 4'd2, 4'd1};
    bus.dmg_req = 4'b0011;
    cyc(1);
    bus.dmg_req = '0;
    lit("pair1_ack", int'(bus.dmg_ack), 1);
    lit("pair1_hp", int'(char_hp), 7);
    ticks(IFR);
    bus.dmg_req = 4'b0011;
    cyc(1);
    bus.dmg_req = '0;
    lit("pair2_ack", int'(bus.dmg_ack), 2);
    lit("pair2_hp", int'(char_hp), 5);
    lit("model_pair2_hp", e_hp, 5);
    ticks(IFR);
    start(8);
    hit(0, 3);
    lit("hit_ack", int'(bus.dmg_ack), 1);
    lit("hit_hp", int'(char_hp), 5);
    lit("hit_pulse_on", int'(hit_pulse), 1);
    lit("hit_inv", int'(invuln), 1);
    cyc(1);
    hit(2, 4);
    lit("inv_discard_ack", int'(bus.dmg_ack), 4);
    lit("inv_discard_hp", int'(char_hp), 5);
    ticks(IFR - 1);
    lit("inv_still", int'(invuln), 1);
    ticks(1);
    lit("inv_end", int'(invuln), 0);
    bus.heal_amt = 4'd2;
    bus.heal_req = 1'b1;
    cyc(1);
    bus.heal_req = 1'b0;
    lit("heal_ack", int'(bus.heal_ack), 1);
    lit("heal_hp", int'(char_hp), 7);
    cyc(1);
    bus.heal_amt = 4'd4;
    bus.heal_req = 1'b1;
    bus.dmg_req[3] = 1'b1;
    bus.dmg_amt[15:12] = 4'd2;
    cyc(1);
    bus.dmg_req = '0;
    lit("prio_dmg_ack", int'(bus.dmg_ack), 8);
    lit("prio_hp", int'(char_hp), 5);
    lit("prio_heal_wait", int'(bus.heal_ack), 0);
    cyc(1);
    bus.heal_req = 1'b0;
    lit("prio_heal_ack", int'(bus.heal_ack), 1);
    lit("prio_heal_sat", int'(char_hp), 8);
    ticks(IFR);
    hit(1, 0);
    lit("zero_ack", int'(bus.dmg_ack), 2);
    lit("zero_hp", int'(char_hp), 8);
    lit("zero_no_pulse", int'(hit_pulse), 0);
    lit("zero_no_inv", int'(invuln), 0);
    cyc(1);
    hit(1, 6);
    lit("pre_death_hp", int'(char_hp), 2);
    ticks(IFR);
    hit(2, 5);
    lit("death_hp", int'(char_hp), 0);
    lit("death_alive", int'(alive), 0);
    lit("death_pulse", int'(hit_pulse), 1);
    cyc(1);
    hit(0, 3);
    lit("dead_ack", int'(bus.dmg_ack), 1);
    lit("dead_hp", int'(char_hp), 0);
    bus.heal_amt = 4'd3;
    bus.heal_req = 1'b1;
    cyc(2);
    lit("dead_no_heal", int'(bus.heal_ack), 0);
    bus.heal_req = 1'b0;
    start(0);
    lit("start_max0_hp", int'(char_hp), 1);
    lit("restart_alive", int'(alive), 1);
    start(15);
    lit("start_max15_hp", int'(char_hp), 15);
    game_active = 2'b00;
    cyc(1);
    lit("pause_alive", int'(alive), 0);
    lit("pause_hp", int'(char_hp), 15);
    hit(0, 3);
    lit("pause_no_ack", int'(bus.dmg_ack), 0);
    game_active = 2'b01;
    cyc(1);
    lit("idle_stays", int'(alive), 0);
    start(15);
    hit(0, 1);
    lit("edge_hp", int'(char_hp), 14);
    ticks(IFR - 1);
    frame_tick = 1'b1;
    bus.dmg_req[2] = 1'b1;
    bus.dmg_amt[11:8] = 4'd3;
    cyc(1);
    frame_tick = 1'b0;
    bus.dmg_req = '0;
    lit("edge_ack", int'(bus.dmg_ack), 4);
    lit("edge_hp_kept", int'(char_hp), 14);
    lit("edge_inv_off", int'(invuln), 0);
    cyc(1);
    hit(1, 2);
    lit("rst_mid_inv", int'(invuln), 1);
    rst = 1'b0;
    #1;
    lit("async_hp", int'(char_hp), 0);
    lit("async_inv", int'(invuln), 0);
    lit("async_alive", int'(alive), 0);
    lit("async_pulse", int'(hit_pulse), 0);
    cyc(2);
    rst = 1'b1;
    cyc(1);
`ifdef CHAR_HP_REGEN_EN
    start(8);
    hit(0, 1);
    ticks(IFR);
    ticks(RGF - 1);
    lit("regen_before", int'(char_hp), 7);
    ticks(1);
    lit("regen_after", int'(char_hp), 8);
`endif
    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
